// File: rtl/seq_detector_param_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int LEN_MAX = 16;
  localparam int FILL_W  = $clog2(LEN_MAX + 1);

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;

  // Coarse view of the fill counter: how many genuine samples are in the history.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } fill_state_e;

  // Map a fill count onto EMPTY / FILLING / ARMED for a pattern of length len.
  function automatic fill_state_e fill_state(input logic [FILL_W-1:0] fill,
                                             input int unsigned len);
    if (fill == '0)
      return ST_EMPTY;
    else if (32'(fill) >= len)
      return ST_ARMED;
    else
      return ST_FILLING;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Signal bundle between a serial bit source and the pattern detector.
// Handshake: en is a one-sided valid qualifier for x; the detector has no
// ready and consumes x on every posedge where en=1 (load has priority and
// then x is dropped). found/match_cnt are registered results, valid every cycle.
interface seq_detector_param_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;

  logic              x;
  logic              en;
  logic              overlap;
  logic              load;
  logic [LEN-1:0]    pattern_in;
  logic              found;
  logic [CNT_W-1:0]  match_cnt;
  fill_state_e       state_dbg;

  modport master (
    output x, en, overlap, load, pattern_in,
    input  found, match_cnt, state_dbg
  );

  modport slave (
    input  x, en, overlap, load, pattern_in,
    output found, match_cnt, state_dbg
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins; otherwise count up until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: programmable LEN-bit pattern, overlap select,
// sample enable, registered one-cycle found flag and saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter int             CNT_W   = 8,
  parameter logic [LEN-1:0] PAT_RST = 4'b1001
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  localparam logic [FILL_W-1:0] LEN_F = FILL_W'(LEN);
  localparam logic [FILL_W-1:0] LEN_M1 = FILL_W'(LEN - 1);

  logic [LEN-1:0]    pat_q, pat_d;
  logic [LEN-1:0]    hist, hist_d;
  logic [LEN-1:0]    nxt;
  logic [FILL_W-1:0] fill, fill_d;
  logic              found_q, found_d;
  logic              match;

  // State registers; reset overrides everything including load and en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q   <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      found_q <= NOTFOUND;
    end else begin
      pat_q   <= pat_d;
      hist    <= hist_d;
      fill    <= fill_d;
      found_q <= found_d;
    end
  end

  // Next-state: load > en sample > idle. fill gates matching so stale history
  // bits (e.g. zeros after reset) can never complete a pattern.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist;
    fill_d  = fill;
    found_d = NOTFOUND;
    match   = 1'b0;
    nxt     = {hist[LEN-2:0], bus.x};
    if (bus.load) begin
      pat_d  = bus.pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en) begin
      hist_d = nxt;
      fill_d = (fill >= LEN_F) ? LEN_F : fill + FILL_W'(1);
      match  = (nxt == pat_q) && (fill >= LEN_M1);
      if (match) begin
        found_d = FOUND;
        if (!bus.overlap)
          fill_d = '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .clr (!reset),
    .inc (match),
    .q   (bus.match_cnt)
  );

  assign bus.found     = found_q;
  assign bus.state_dbg = fill_state(fill, LEN);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, saturation corner on a
// small instance, then randomized traffic against a sample-queue model.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int LEN   = 4;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  seq_detector_param_if #(.LEN(LEN), .CNT_W(CNT_W)) bus ();
  seq_detector_param #(.LEN(LEN), .CNT_W(CNT_W), .PAT_RST(4'b1001)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_detector_param_if #(.LEN(2), .CNT_W(2)) bus2 ();
  seq_detector_param #(.LEN(2), .CNT_W(2), .PAT_RST(2'b11)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the genuine samples since the last reset/load/non-overlap match;
  // a match is simply "the last LEN samples spell the pattern".
  bit          mq[$];
  logic [3:0]  m_pat   = 4'b1001;
  logic        m_found = 1'b0;
  logic [7:0]  m_cnt   = '0;

  task automatic model_step(input logic rn, ld, e, xb, ov, input logic [3:0] p);
    bit hit;
    if (!rn) begin
      mq.delete(); m_pat = 4'b1001; m_found = 1'b0; m_cnt = '0;
    end else if (ld) begin
      m_pat = p; mq.delete(); m_found = 1'b0;
    end else if (e) begin
      mq.push_back(xb);
      if (mq.size() > LEN) void'(mq.pop_front());
      hit = (mq.size() == LEN);
      for (int i = 0; i < LEN; i++)
        if (hit && (mq[i] != m_pat[LEN-1-i])) hit = 1'b0;
      m_found = hit;
      if (hit) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (!ov) mq.delete();
      end
    end else begin
      m_found = 1'b0;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (mq.size() == 0) return 2'd0;
    if (mq.size() >= LEN) return 2'd2;
    return 2'd1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rn, ld, e, xb, ov, input logic [3:0] p);
    reset = rn; bus.load = ld; bus.en = e; bus.x = xb; bus.overlap = ov; bus.pattern_in = p;
  endtask

  // One edge on the main DUT; model sees the same inputs, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step(reset, bus.load, bus.en, bus.x, bus.overlap, bus.pattern_in);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rn, ld, e, xb, ov;
    logic [3:0] p;
    logic       ef;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic rn, ld, e, xb, ov, input logic [3:0] p,
                      input logic ef, input logic [7:0] ec);
    vec_t v;
    v.rn = rn; v.ld = ld; v.e = e; v.xb = xb; v.ov = ov; v.p = p; v.ef = ef; v.ec = ec;
    tbl.push_back(v);
  endtask

  logic [10:0] exp_q[$];

  initial begin
    logic [10:0] exp_v;
    logic        ef6 [6];
    logic [1:0]  ec6 [6];

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    reset2 = 1'b0;
    bus2.x = 1'b1; bus2.en = 1'b1; bus2.overlap = 1'b1; bus2.load = 1'b0; bus2.pattern_in = 2'b11;

    // T1: overlap, 1001 on 1,0,0,1,0,0,1 -> pulses after 4th and 7th; load keeps count
    addv(0,0,0,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 1,1); addv(1,0,1,0,1,4'h0, 0,1); addv(1,0,1,0,1,4'h0, 0,1);
    addv(1,0,1,1,1,4'h0, 1,2);
    addv(1,1,1,1,1,4'h9, 0,2);
    // T2: non-overlap, same stream -> single pulse
    addv(0,0,0,0,0,4'h0, 0,0);
    addv(1,0,1,1,0,4'h0, 0,0); addv(1,0,1,0,0,4'h0, 0,0); addv(1,0,1,0,0,4'h0, 0,0);
    addv(1,0,1,1,0,4'h0, 1,1); addv(1,0,1,0,0,4'h0, 0,1); addv(1,0,1,0,0,4'h0, 0,1);
    addv(1,0,1,1,0,4'h0, 0,1);
    // T3: en on alternate edges, idle x toggles ignored
    addv(0,0,0,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 0,0); addv(1,0,0,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0);
    addv(1,0,0,1,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,0,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 1,1); addv(1,0,0,1,1,4'h0, 0,1); addv(1,0,0,0,1,4'h0, 0,1);
    // T4: load 1101 after 1,1,0 clears history; no early match
    addv(0,0,0,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'hD, 0,0); addv(1,0,1,1,1,4'hD, 0,0); addv(1,0,1,0,1,4'hD, 0,0);
    addv(1,1,1,1,1,4'hD, 0,0);
    addv(1,0,1,1,1,4'hD, 0,0); addv(1,0,1,1,1,4'hD, 0,0); addv(1,0,1,0,1,4'hD, 0,0);
    addv(1,0,1,1,1,4'hD, 1,1);
    // T5: reset mid-stream after 1,0,0 discards history and restores 1001
    addv(0,0,0,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0);
    addv(0,0,1,1,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0);
    addv(1,0,1,1,1,4'h0, 1,1);
    // T7: pattern 0000 needs four genuine zeros, then overlaps every sample
    addv(0,0,0,0,1,4'h0, 0,0);
    addv(1,1,0,0,1,4'h0, 0,0);
    addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0); addv(1,0,1,0,1,4'h0, 0,0);
    addv(1,0,1,0,1,4'h0, 1,1); addv(1,0,1,0,1,4'h0, 1,2); addv(1,0,0,0,1,4'h0, 0,2);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rn, tbl[i].ld, tbl[i].e, tbl[i].xb, tbl[i].ov, tbl[i].p);
      tick();
      check($sformatf("vec%0d_found", i), 32'(bus.found), 32'(tbl[i].ef));
      check($sformatf("vec%0d_cnt", i), 32'(bus.match_cnt), 32'(tbl[i].ec));
    end
    check("state_after_t7", 32'(bus.state_dbg), 32'(ST_ARMED));

    // T6: LEN=2, CNT_W=2, PAT 11, six ones -> five pulses, count saturates at 3
    ef6 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ec6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(posedge clk); #1;
    check("t6_reset_found", 32'(bus2.found), 32'd0);
    check("t6_reset_cnt", 32'(bus2.match_cnt), 32'd0);
    check("t6_reset_state", 32'(bus2.state_dbg), 32'(ST_EMPTY));
    reset2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("t6_found%0d", i), 32'(bus2.found), 32'(ef6[i]));
      check($sformatf("t6_cnt%0d", i), 32'(bus2.match_cnt), 32'(ec6[i]));
    end

    // Randomized traffic against the model
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
      exp_q.push_back({model_state(), m_found, m_cnt});
      exp_v = exp_q.pop_front();
      check("rnd_found", 32'(bus.found), 32'(exp_v[8]));
      check("rnd_cnt", 32'(bus.match_cnt), 32'(exp_v[7:0]));
      check("rnd_state", 32'(bus.state_dbg), 32'(exp_v[10:9]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
